// File: rtl/wbm_uart_sched.sv
// wbm_uart_sched: Wishbone master that drives a memory-mapped UART slave for a
// byte-stream client. After reset it writes CTRL, then polls STATUS and moves
// client TX bytes into WDATA. With UART_SCHED_RX_EN defined it also moves
// RDATA bytes out to the client, round-robin against TX.
//
// Client handshakes: a byte transfers on any clock edge where valid and ready
// are both high. Valid must not depend on ready. The producer holds data
// stable while valid is high and ready is low.
//
// Optional feature macro: UART_SCHED_RX_EN (RX path, RX eligibility and
// round-robin arbitration).
module wbm_uart_sched #(
   parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
   parameter logic [31:0] CTRL_INIT   = 32'h0000_0000,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_tx_valid,
   input  logic [7:0]  i_tx_data,
   output logic        o_tx_ready,
   output logic        o_rx_valid,
   output logic [7:0]  o_rx_data,
   input  logic        i_rx_ready,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic [31:0] i_wb_data,
   output logic        o_err,
   output logic [2:0]  o_dbg_state
);

   localparam logic [2:0] S_INIT = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_STAT = 3'd2;
   localparam logic [2:0] S_TXW  = 3'd3;
   localparam logic [2:0] S_RXR  = 3'd4;

   localparam logic [31:0] A_CTRL  = BASE_ADDR;
   localparam logic [31:0] A_STAT  = BASE_ADDR + 32'h4;
   localparam logic [31:0] A_RDATA = BASE_ADDR + 32'h8;
   localparam logic [31:0] A_WDATA = BASE_ADDR + 32'hC;

   // The counter already reads 1 after the request cycle, so the last
   // ack-less cycle allowed is seen when it holds ACK_TIMEOUT-1.
   localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

   logic [2:0] state;
   logic [7:0] tmr;
   logic       hold_full;
   logic [7:0] hold_data;
   logic       last_tx;

   logic tx_accept;
   logic req_only;
   logic bus_done;
   logic tmo_hit;
   logic tx_work;
   logic rx_work;
   logic tx_elig;
   logic rx_elig;
   logic grant_tx;
   logic grant_rx;
   logic unused_bits;

   assign o_dbg_state = state;
   assign o_tx_ready  = !hold_full && (state != S_INIT);
   assign tx_accept   = i_tx_valid && o_tx_ready;

   // Request accepted without a same-cycle ack: stb drops, ack wait begins.
   assign req_only = o_wb_cyc && o_wb_stb && !i_wb_stall && !i_wb_ack;
   // An ack counts in the request cycle itself or in any later wait cycle.
   assign bus_done = o_wb_cyc && i_wb_ack && (!o_wb_stb || !i_wb_stall);
   assign tmo_hit  = o_wb_cyc && !o_wb_stb && !i_wb_ack && (tmr == TMO_LAST);

   // A byte accepted this very cycle already counts as TX work so the STAT
   // poll starts on the next cycle.
   assign tx_work = hold_full || tx_accept;
   assign tx_elig = hold_full && !i_wb_data[0];

`ifdef UART_SCHED_RX_EN
   logic       rx_full;
   logic [7:0] rx_byte;

   assign rx_work     = !rx_full;
   assign rx_elig     = rx_work && !i_wb_data[3];
   assign o_rx_valid  = rx_full;
   assign o_rx_data   = rx_byte;
   assign unused_bits = &{1'b0, i_wb_data[31:8]};

   // RX output slot: filled by an acked RDATA read, emptied by the client.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_full <= 1'b0;
         rx_byte <= 8'h00;
      end else if ((state == S_RXR) && bus_done) begin
         rx_full <= 1'b1;
         rx_byte <= i_wb_data[7:0];
      end else if (rx_full && i_rx_ready) begin
         rx_full <= 1'b0;
      end
   end
`else
   assign rx_work     = 1'b0;
   assign rx_elig     = 1'b0;
   assign o_rx_valid  = 1'b0;
   assign o_rx_data   = 8'h00;
   assign unused_bits = &{1'b0, i_wb_data[31:1], i_rx_ready};
`endif

   // Both eligible: take the side that did not win last time.
   assign grant_tx = tx_elig && (!rx_elig || !last_tx);
   assign grant_rx = rx_elig && !grant_tx;

   // Scheduler FSM, bus cycle engine, TX holding register and error flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_INIT;
         o_wb_cyc  <= 1'b0;
         o_wb_stb  <= 1'b0;
         o_wb_we   <= 1'b0;
         o_wb_addr <= 32'h0;
         o_wb_data <= 32'h0;
         tmr       <= 8'h00;
         hold_full <= 1'b0;
         hold_data <= 8'h00;
         last_tx   <= 1'b0;
         o_err     <= 1'b0;
      end else begin
         if (tx_accept) begin
            hold_full <= 1'b1;
            hold_data <= i_tx_data;
         end

         if (req_only) begin
            o_wb_stb <= 1'b0;
            tmr      <= 8'd1;
         end else if (o_wb_cyc && !o_wb_stb && !i_wb_ack) begin
            tmr <= tmr + 8'd1;
         end

         // Timeout abandons the access; a held TX byte stays for a retry.
         if (tmo_hit) begin
            o_wb_cyc <= 1'b0;
            o_err    <= 1'b1;
            state    <= S_IDLE;
         end

         case (state)
            S_INIT: begin
               if (!o_wb_cyc) begin
                  o_wb_cyc  <= 1'b1;
                  o_wb_stb  <= 1'b1;
                  o_wb_we   <= 1'b1;
                  o_wb_addr <= A_CTRL;
                  o_wb_data <= CTRL_INIT;
               end else if (bus_done) begin
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (tx_work || rx_work) begin
                  o_wb_cyc  <= 1'b1;
                  o_wb_stb  <= 1'b1;
                  o_wb_we   <= 1'b0;
                  o_wb_addr <= A_STAT;
                  state     <= S_STAT;
               end
            end
            S_STAT: begin
               if (bus_done) begin
                  if (grant_tx) begin
                     o_wb_cyc  <= 1'b1;
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= 1'b1;
                     o_wb_addr <= A_WDATA;
                     o_wb_data <= {24'h0, hold_data};
                     last_tx   <= 1'b1;
                     state     <= S_TXW;
                  end else if (grant_rx) begin
                     o_wb_cyc  <= 1'b1;
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= 1'b0;
                     o_wb_addr <= A_RDATA;
                     last_tx   <= 1'b0;
                     state     <= S_RXR;
                  end else begin
                     o_wb_cyc <= 1'b0;
                     o_wb_stb <= 1'b0;
                     state    <= S_IDLE;
                  end
               end
            end
            S_TXW: begin
               if (bus_done) begin
                  hold_full <= 1'b0;
                  o_wb_cyc  <= 1'b0;
                  o_wb_stb  <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            S_RXR: begin
               if (bus_done) begin
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: begin
               o_wb_cyc <= 1'b0;
               o_wb_stb <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wbm_uart_sched.sv
// Testbench for wbm_uart_sched: behavioural Wishbone UART slave, directed
// vectors with hand-computed expectations, request scoreboard, summary line.
module tb_wbm_uart_sched;

   localparam logic [31:0] BASE      = 32'h2000_0000;
   localparam logic [31:0] A_CTRL    = 32'h2000_0000;
   localparam logic [31:0] A_STAT    = 32'h2000_0004;
   localparam logic [31:0] A_RDATA   = 32'h2000_0008;
   localparam logic [31:0] A_WDATA   = 32'h2000_000C;
   localparam logic [31:0] CTRL_INIT = 32'h0000_0000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        tx_valid, tx_ready, rx_valid, rx_ready;
   logic [7:0]  tx_data, rx_data;
   logic        wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_addr, wb_data;
   logic        err;
   logic [2:0]  dbg_state;

   logic        stall_en, nack_wr;
   logic        s_ack;
   logic [31:0] s_rdata;
   logic [31:0] stat_val, rdata_val;
   int          busy_until = 0;
   int          n_stat = 0;
   int          n_txw = 0;
   int          n_rxr = 0;

   logic [64:0] exp_q[$];
   logic [64:0] got_q[$];
   logic        g_q[$];

   int checks = 0;
   int failures = 0;

   wbm_uart_sched #(
      .BASE_ADDR  (BASE),
      .CTRL_INIT  (CTRL_INIT),
      .ACK_TIMEOUT(16)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_tx_valid (tx_valid),
      .i_tx_data  (tx_data),
      .o_tx_ready (tx_ready),
      .o_rx_valid (rx_valid),
      .o_rx_data  (rx_data),
      .i_rx_ready (rx_ready),
      .o_wb_cyc   (wb_cyc),
      .o_wb_stb   (wb_stb),
      .o_wb_we    (wb_we),
      .o_wb_addr  (wb_addr),
      .o_wb_data  (wb_data),
      .i_wb_ack   (s_ack),
      .i_wb_stall (stall_en),
      .i_wb_data  (s_rdata),
      .o_err      (err),
      .o_dbg_state(dbg_state)
   );

   // ---------------- UART slave model ----------------
   // Acks one cycle after each accepted request; logs every request.
   always @(posedge clk) begin
      s_ack <= 1'b0;
      if (!rst && wb_cyc && wb_stb && !stall_en) begin
         got_q.push_back({wb_we, wb_addr, wb_we ? wb_data : 32'h0});
         if (wb_addr == A_STAT) begin
            s_rdata <= (n_stat < busy_until) ? 32'h1 : stat_val;
            n_stat = n_stat + 1;
            s_ack <= 1'b1;
         end else if (wb_addr == A_WDATA) begin
            n_txw = n_txw + 1;
            g_q.push_back(1'b1);
            s_ack <= !nack_wr;
         end else if (wb_addr == A_RDATA) begin
            n_rxr = n_rxr + 1;
            g_q.push_back(1'b0);
            s_rdata <= rdata_val;
            s_ack <= 1'b1;
         end else begin
            s_ack <= 1'b1;
         end
      end
   end

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sb_drain(input string name);
      logic [64:0] g;
      logic [64:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q.size() == 0) begin
            failures++;
            $display("FAIL %s_missing: got none expected %h", name, e);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               failures++;
               $display("FAIL %s_req: got %h expected %h", name, g, e);
            end
         end
      end
      check({name, "_extra"}, 32'(got_q.size()), 32'd0);
      got_q.delete();
   endtask

   task automatic wait_ready(input string name, input int limit);
      int k;
      k = 0;
      while (!tx_ready && k < limit) begin
         @(negedge clk);
         k++;
      end
      check({name, "_ready"}, 32'(tx_ready), 32'd1);
   endtask

   task automatic wait_stb(input string name, input int limit);
      int k;
      k = 0;
      while (!(wb_cyc && wb_stb) && k < limit) begin
         @(negedge clk);
         k++;
      end
      check({name, "_stb"}, 32'(wb_cyc && wb_stb), 32'd1);
   endtask

   typedef struct {
      logic [7:0]  d;
      logic [31:0] exp_wdata;
   } tx_vec_t;

   tx_vec_t vecs[4];
   logic    exp_grants[4];

   // ---------------- test sequence ----------------
   initial begin
      int k;
      int txw0;
      int stat0;

      rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
      stall_en = 1'b0; nack_wr = 1'b0;
      stat_val = 32'h0000_000A; rdata_val = 32'h0000_005A;
      s_rdata = 32'h0;

      vecs[0] = '{8'h41, 32'h0000_0041};
      vecs[1] = '{8'h00, 32'h0000_0000};
      vecs[2] = '{8'hFF, 32'h0000_00FF};
      vecs[3] = '{8'hA5, 32'h0000_00A5};
      exp_grants[0] = 1'b1; exp_grants[1] = 1'b0;
      exp_grants[2] = 1'b1; exp_grants[3] = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_cyc_stb_we", 32'({wb_cyc, wb_stb, wb_we}), 32'd0);
      check("rst_addr", wb_addr, 32'h0);
      check("rst_data", wb_data, 32'h0);
      check("rst_tx_ready", 32'(tx_ready), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      // CTRL write immediately after reset
      got_q.delete();
      exp_q.push_back({1'b1, A_CTRL, CTRL_INIT});
      rst = 1'b0;
      @(negedge clk);
      check("init_cyc_stb_we", 32'({wb_cyc, wb_stb, wb_we}), 32'b111);
      check("init_addr", wb_addr, A_CTRL);
      check("init_data", wb_data, CTRL_INIT);
      check("init_tx_ready", 32'(tx_ready), 32'd0);
      @(negedge clk);
      check("init_wait", 32'({wb_cyc, wb_stb}), 32'b10);
      @(negedge clk);
      check("init_ready_after_ack", 32'(tx_ready), 32'd1);
`ifndef UART_SCHED_RX_EN
      check("init_cyc_drop", 32'(wb_cyc), 32'd0);
`endif
      sb_drain("init");

`ifndef UART_SCHED_RX_EN
      // Table: one byte from IDLE -> STAT c1/c2, TXW c3/c4, ready c5
      for (int i = 0; i < 4; i++) begin
         wait_ready("vec_pre", 20);
         exp_q.push_back({1'b0, A_STAT, 32'h0});
         exp_q.push_back({1'b1, A_WDATA, vecs[i].exp_wdata});
         tx_valid = 1'b1; tx_data = vecs[i].d;
         @(negedge clk);
         tx_valid = 1'b0;
         check("vec_c1_ctl", 32'({wb_cyc, wb_stb, wb_we}), 32'b110);
         check("vec_c1_addr", wb_addr, A_STAT);
         check("vec_c1_ready", 32'(tx_ready), 32'd0);
         @(negedge clk);
         check("vec_c2_ctl", 32'({wb_cyc, wb_stb}), 32'b10);
         @(negedge clk);
         check("vec_c3_ctl", 32'({wb_cyc, wb_stb, wb_we}), 32'b111);
         check("vec_c3_addr", wb_addr, A_WDATA);
         check("vec_c3_data", wb_data, vecs[i].exp_wdata);
         @(negedge clk);
         check("vec_c4_ctl", 32'({wb_cyc, wb_stb, tx_ready}), 32'b100);
         @(negedge clk);
         check("vec_c5_ready", 32'({tx_ready, wb_cyc}), 32'b10);
         sb_drain("vec");
      end

      // tx_full for three polls, then the write of the held byte
      busy_until = n_stat + 3;
      stat0 = n_stat; txw0 = n_txw;
      repeat (4) exp_q.push_back({1'b0, A_STAT, 32'h0});
      exp_q.push_back({1'b1, A_WDATA, 32'h0000_003C});
      tx_valid = 1'b1; tx_data = 8'h3C;
      @(negedge clk);
      tx_valid = 1'b0;
      k = 0;
      while (!tx_ready && k < 60) begin
         @(negedge clk);
         k++;
      end
      check("busy_cycles_until_ready", 32'(k), 32'd13);
      check("busy_stat_reads", 32'(n_stat - stat0), 32'd4);
      check("busy_writes", 32'(n_txw - txw0), 32'd1);
      sb_drain("busy");

      // WDATA never acked: timeout after 16 cycles, then retry
      nack_wr = 1'b1;
      txw0 = n_txw;
      exp_q.push_back({1'b0, A_STAT, 32'h0});
      exp_q.push_back({1'b1, A_WDATA, 32'h0000_0077});
      exp_q.push_back({1'b0, A_STAT, 32'h0});
      exp_q.push_back({1'b1, A_WDATA, 32'h0000_0077});
      tx_valid = 1'b1; tx_data = 8'h77;
      @(negedge clk);
      tx_valid = 1'b0;
      k = 0;
      while (!(wb_stb && wb_we) && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("tmo_write_req", 32'(wb_stb && wb_we), 32'd1);
      repeat (15) @(negedge clk);
      check("tmo_last_wait", 32'({wb_cyc, err}), 32'b10);
      @(negedge clk);
      check("tmo_drop", 32'({wb_cyc, err}), 32'b01);
      check("tmo_held_ready", 32'(tx_ready), 32'd0);
      nack_wr = 1'b0;
      wait_ready("tmo_retry", 40);
      check("tmo_write_count", 32'(n_txw - txw0), 32'd2);
      check("tmo_err_sticky", 32'(err), 32'd1);
      sb_drain("tmo");

      // RX output tied off in this build
      rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("norx_valid", 32'({rx_valid, rx_data}), 32'd0);
      rx_ready = 1'b0;
`endif

      // Reset while a stalled STAT holds stb
      stall_en = 1'b1;
      wait_ready("rstmid_pre", 20);
      tx_valid = 1'b1; tx_data = 8'h99;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rstmid_stall_stb", 32'({wb_cyc, wb_stb}), 32'b11);
      check("rstmid_stall_addr", wb_addr, A_STAT);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_bus_drop", 32'({wb_cyc, wb_stb}), 32'b00);
      check("rstmid_err", 32'(err), 32'd0);
      check("rstmid_tx_ready", 32'(tx_ready), 32'd0);
      rst = 1'b0; stall_en = 1'b0;
      got_q.delete();
      exp_q.push_back({1'b1, A_CTRL, CTRL_INIT});
      txw0 = n_txw;
      @(negedge clk);
      check("rstmid_ctrl_ctl", 32'({wb_cyc, wb_stb, wb_we}), 32'b111);
      check("rstmid_ctrl_addr", wb_addr, A_CTRL);
      repeat (2) @(negedge clk);
      check("rstmid_ready", 32'(tx_ready), 32'd1);
      sb_drain("rstmid");
`ifndef UART_SCHED_RX_EN
      repeat (10) @(negedge clk);
      check("rstmid_byte_dropped", 32'(n_txw - txw0), 32'd0);
`endif

`ifdef UART_SCHED_RX_EN
      // Phase A: freeze a STAT poll, create a TX/RX tie, TX wins first
      stall_en = 1'b1;
      wait_stb("rxa_freeze", 20);
      g_q.delete();
      tx_valid = 1'b1; tx_data = 8'h41;
      @(negedge clk);
      tx_valid = 1'b0;
      stat_val = 32'h0000_0002;
      @(negedge clk);
      stall_en = 1'b0;
      k = 0;
      while (!rx_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("rxa_valid", 32'(rx_valid), 32'd1);
      check("rxa_grant_count", 32'(g_q.size()), 32'd2);
      if (g_q.size() >= 2) begin
         check("rxa_grant0", 32'(g_q[0]), 32'd1);
         check("rxa_grant1", 32'(g_q[1]), 32'd0);
      end
      repeat (10) @(negedge clk);
      check("rxa_hold_valid", 32'(rx_valid), 32'd1);
      check("rxa_hold_data", 32'(rx_data), 32'h5A);
      check("rxa_idle", 32'(wb_cyc), 32'd0);

      // Phase B: client drains, TX always pending: grants alternate
      stall_en = 1'b1;
      rx_ready = 1'b1;
      @(negedge clk);
      check("rxb_consumed", 32'(rx_valid), 32'd0);
      wait_stb("rxb_freeze", 20);
      g_q.delete();
      tx_valid = 1'b1; tx_data = 8'h42;
      @(negedge clk);
      stall_en = 1'b0;
      k = 0;
      while (g_q.size() < 4 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("rxb_grant_count", 32'(g_q.size() >= 4), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (i < g_q.size())
            check("rxb_grant", 32'(g_q[i]), 32'(exp_grants[i]));
      end
      check("rxb_data", 32'(rx_data), 32'h5A);
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      repeat (10) @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global bound on run time
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/wbm_uart_sched.md
# wbm_uart_sched

Wishbone master that sequences the memory-mapped UART slave (CTRL/STATUS/RDATA/WDATA at BASE_ADDR+0/4/8/C) on behalf of a byte-stream client. After reset it programs CTRL once, then polls STATUS. It moves client TX bytes into WDATA and, optionally, RDATA bytes out to the client. It round-robins between TX and RX work. It sits between a streaming producer/consumer and the UART slave's Wishbone port.

## Interface
- BASE_ADDR, 32'h20000000, UART register base.
- CTRL_INIT, 32'h00000000, value written to CTRL after reset.
- ACK_TIMEOUT, 16, cycles to wait for ack after stb is accepted (2..255).
- Clock and reset: one clock; reset is synchronous and active-high.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_tx_valid  in  1  client TX byte valid.
- i_tx_data  in  8  client TX byte.
- o_tx_ready  out  1  TX holding register empty and not in INIT.
- o_rx_valid  out  1  RX byte available (compiled in by UART_SCHED_RX_EN, else constant 0).
- o_rx_data  out  8  RX byte.
- i_rx_ready  in  1  client consumes RX byte.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
- o_wb_addr  out  32  register address.
- o_wb_data  out  32  write data; {24'b0, byte} for WDATA.
- i_wb_ack, i_wb_stall  in  1 each  slave handshake.
- i_wb_data  in  32  read data.
- o_err  out  1  sticky ack-timeout flag.

## Operation
- States: INIT, IDLE, STAT, TXW, RXR, with an ack-wait sub-phase in each bus state.
- INIT: write CTRL_INIT to BASE_ADDR+0, then go to IDLE.
- TX holding register: one byte. It loads on i_tx_valid&o_tx_ready and clears when the WDATA write is acked.
- RX output slot: one byte. It loads when an RDATA read is acked. o_rx_valid clears on i_rx_ready.
- IDLE leaves for STAT when TX work or RX work exists.
  - TX work: TX holding register full.
  - RX work (RX_EN only): RX output slot empty.
- STAT: read BASE_ADDR+4. Status bits: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
- On STAT ack, two eligibility tests apply.
  - TX eligible: holding full and tx_full=0.
  - RX eligible: RX work and rx_empty=0.
  - If both are eligible, grant opposite of last_grant; else grant the eligible one; else return to IDLE.
  - last_grant resets to RX, so TX wins the first tie.
- TXW: write holding byte to BASE_ADDR+C, then go to IDLE.
- RXR: read BASE_ADDR+8, latch i_wb_data[7:0] into the RX output slot, then go to IDLE.
- Bus cycle rules:
  - Assert cyc+stb; hold stb, addr, we and data stable while i_wb_stall=1.
  - The first cycle with stb&!stall is the request. Drop stb next cycle but keep cyc until ack.
  - cyc drops in the cycle after ack.
  - An ack arriving in the request cycle itself is accepted.
- Timeout:
  - An 8-bit counter starts at the request and counts cycles without ack.
  - At ACK_TIMEOUT: drop cyc, set o_err, go to IDLE.
  - A pending TX byte is retained and retried. A timed-out read discards its data.
  - o_err clears only on reset.
- Reset mid-transaction:
  - cyc/stb drop at the next edge.
  - The holding byte, RX slot and o_err are cleared.
  - The FSM re-enters INIT.

## Timing
- Reset values: o_wb_cyc/stb/we 0, o_wb_addr 0, o_wb_data 0, o_tx_ready 0, o_rx_valid 0, o_rx_data 0, o_err 0.
- All outputs are registered except o_tx_ready. o_tx_ready is decoded from holding-empty and state≠INIT.
- First cycle after reset deasserts: CTRL write stb=1.
- Zero-stall slave that acks one cycle after stb gives 2 cycles per transaction.
- A byte accepted from IDLE in cycle 0 produces this sequence:
  - STAT stb in cycle 1, ack in cycle 2.
  - TXW stb in cycle 3, ack in cycle 4.
  - o_tx_ready=1 in cycle 5.
- Simultaneous i_rx_ready and RDATA ack cannot occur: RXR is only entered with the slot empty.
- A client byte offered during TXW of the previous byte is not accepted until the holding register clears.

## Configuration
- UART_SCHED_RX_EN defined: the RX path, RX eligibility and round-robin arbitration are present.
- UART_SCHED_RX_EN undefined:
  - o_rx_valid=0, o_rx_data=0, i_rx_ready ignored.
  - IDLE leaves only for TX work; RXR is unreachable.

## Test plan
- Reset, zero-stall slave: cycle 1 shows cyc=stb=we=1, addr 0x20000000, data CTRL_INIT. o_tx_ready rises after the ack.
- Send 0x41 with status=0x0: STAT read at 0x20000004 follows, then WDATA write 0x00000041 at 0x2000000C. Cycle counts match Timing.
- Status tx_full=1 for 3 polls, then 0: three STAT reads, no write, then one write of the held byte. o_tx_ready stays 0 throughout.
- RX_EN, status rx_empty=0, RDATA returns 0x5A, TX byte also pending:
  - TX and RXR grants alternate.
  - o_rx_valid=1 with o_rx_data=0x5A until i_rx_ready.
- Slave never acks a WDATA write: after ACK_TIMEOUT cycles cyc drops and o_err=1. The byte is retried once ack returns.
- i_rst pulsed while stalled with stb held: cyc/stb are 0 next cycle, the FSM restarts at the CTRL write, and o_err=0.
